rx_lane_reorder_bitslip: RTL and testbench

- Parametrised successor to the fixed 4-bit bit-reversal stage in the IOD generic RX alignment path.
- Takes LANES lanes of RATIO-bit deserialised words on the fabric clock.
- Per lane: optional bit-order reversal, then a registered bitslip window across consecutive words.
- A request/acknowledge handshake lets the training FSM step the slip position with a settle blanking period. Sits between the IOD RX data output and the word-alignment / training logic.

---
 rtl/rx_lane_reorder_bitslip.sv | 154 +++++++++++++++
 tb/tb_rx_lane_reorder_bitslip.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_lane_reorder_bitslip.sv
// Per-lane optional bit reversal followed by a shared registered bitslip window.
// A request/acknowledge FSM steps the slip position and blanks OUT_VALID while it settles.
module rx_lane_reorder_bitslip #(
    parameter int RATIO          = 4,
    parameter int LANES          = 2,
    parameter bit REV_EN_DEFAULT = 1'b1,
    parameter int SETTLE         = 2
) (
    input  logic                       SCLK,
    input  logic                       RESETN,
    input  logic [LANES*RATIO-1:0]     IN_DATA,
    input  logic                       IN_VALID,
    input  logic                       REV_EN,
    input  logic                       SLIP_REQ,
    output logic                       SLIP_ACK,
    output logic                       SLIP_BUSY,
    output logic [$clog2(RATIO)-1:0]   SLIP_POS,
    output logic                       SLIP_WRAP,
    output logic [LANES*RATIO-1:0]     OUT_DATA,
    output logic                       OUT_VALID
);

    localparam int              W           = LANES * RATIO;
    localparam int              PW          = $clog2(RATIO);
    localparam logic [PW:0]     RATIO_L     = RATIO[PW:0];
    localparam logic [PW-1:0]   POS_MAX     = PW'(RATIO - 1);
    localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE - 1);

    // Handshake: SLIP_REQ is a level sampled only in S_IDLE; SLIP_BUSY covers
    // acceptance through the single-cycle SLIP_ACK; requests elsewhere are dropped.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_SETTLE = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            rev_q, rev_d;
    logic [W-1:0]    prev_q, prev_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            wrap_q, wrap_d;
    logic            wrap_flag_q, wrap_flag_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [W-1:0]         r_data;
    logic [W-1:0]         slip_data;
    logic [2*RATIO-1:0]   ext;
    logic [2*RATIO-1:0]   shifted;
    logic [PW:0]          shamt;

    always_comb begin
        r_data    = '0;
        slip_data = '0;
        ext       = '0;
        shifted   = '0;
        shamt     = RATIO_L - {1'b0, pos_q};
        for (int k = 0; k < LANES; k++) begin
            for (int i = 0; i < RATIO; i++) begin
                r_data[k*RATIO+i] = rev_q ? IN_DATA[k*RATIO+RATIO-1-i] : IN_DATA[k*RATIO+i];
            end
        end
        // Window of RATIO bits taken from {current, previous} word of each lane.
        for (int k = 0; k < LANES; k++) begin
            ext     = {r_data[k*RATIO +: RATIO], prev_q[k*RATIO +: RATIO]};
            shifted = ext >> shamt;
            slip_data[k*RATIO +: RATIO] = shifted[RATIO-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        pos_d       = pos_q;
        cnt_d       = cnt_q;
        wrap_flag_d = wrap_flag_q;
        ack_d       = 1'b0;
        wrap_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (SLIP_REQ) begin
                    state_d = S_STEP;
                    busy_d  = 1'b1;
                end
            end
            S_STEP: begin
                pos_d       = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
                wrap_flag_d = (pos_q == POS_MAX);
                cnt_d       = SETTLE_INIT;
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    ack_d   = 1'b1;
                    wrap_d  = wrap_flag_q;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rev_d       = REV_EN;
        prev_d      = IN_VALID ? r_data : prev_q;
        out_data_d  = IN_VALID ? slip_data : out_data_q;
        // Gate on the next state so the blanking covers every non-idle cycle.
        out_valid_d = IN_VALID && (state_d == S_IDLE);
    end

    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_IDLE;
            rev_q       <= REV_EN_DEFAULT;
            prev_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
            wrap_flag_q <= 1'b0;
            pos_q       <= '0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            rev_q       <= rev_d;
            prev_q      <= prev_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
            wrap_flag_q <= wrap_flag_d;
            pos_q       <= pos_d;
            cnt_q       <= cnt_d;
        end
    end

    assign SLIP_ACK  = ack_q;
    assign SLIP_BUSY = busy_q;
    assign SLIP_POS  = pos_q;
    assign SLIP_WRAP = wrap_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_rx_lane_reorder_bitslip.sv
// Bench for rx_lane_reorder_bitslip: directed scenarios plus random traffic against
// a timeline-based reference model of the slip handshake and data window.
module tb_rx_lane_reorder_bitslip;

    localparam int RATIO  = 4;
    localparam int LANES  = 2;
    localparam int SETTLE = 2;
    localparam int W      = LANES * RATIO;
    localparam int PW     = $clog2(RATIO);
    localparam int MASK   = (1 << RATIO) - 1;

    logic            SCLK;
    logic            RESETN;
    logic [W-1:0]    IN_DATA;
    logic            IN_VALID;
    logic            REV_EN;
    logic            SLIP_REQ;
    logic            SLIP_ACK;
    logic            SLIP_BUSY;
    logic [PW-1:0]   SLIP_POS;
    logic            SLIP_WRAP;
    logic [W-1:0]    OUT_DATA;
    logic            OUT_VALID;

    rx_lane_reorder_bitslip #(
        .RATIO(RATIO), .LANES(LANES), .REV_EN_DEFAULT(1'b1), .SETTLE(SETTLE)
    ) dut (
        .SCLK(SCLK), .RESETN(RESETN), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .REV_EN(REV_EN), .SLIP_REQ(SLIP_REQ), .SLIP_ACK(SLIP_ACK),
        .SLIP_BUSY(SLIP_BUSY), .SLIP_POS(SLIP_POS), .SLIP_WRAP(SLIP_WRAP),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID)
    );

    // clock / reset
    initial begin
        SCLK = 1'b0;
        forever #5 SCLK = ~SCLK;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int n_edge;
    int acc_edge;
    int m_rev;
    int m_prev[LANES];
    int m_wrap_flag;
    int e_out;
    int e_valid;
    int e_ack;
    int e_busy;
    int e_pos;
    int e_wrap;
    int dut_acks;
    int dut_wraps;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edge);
        end
    endtask

    function automatic int rev_f(input int v);
        int res = 0;
        for (int i = 0; i < RATIO; i++) res |= ((v >> i) & 1) << (RATIO - 1 - i);
        return res;
    endfunction

    // Low p output bits come from the top p bits of the previous word.
    function automatic int slip_f(input int r, input int prev, input int p);
        if (p == 0) return r;
        return ((r << p) | (prev >> (RATIO - p))) & MASK;
    endfunction

    task automatic model_reset();
        acc_edge    = -1;
        m_rev       = 1;
        m_wrap_flag = 0;
        e_out = 0; e_valid = 0; e_ack = 0; e_busy = 0; e_pos = 0; e_wrap = 0;
        for (int k = 0; k < LANES; k++) m_prev[k] = 0;
    endtask

    task automatic check_all();
        check_eq("out_data",  32'(OUT_DATA),  32'(e_out));
        check_eq("out_valid", 32'(OUT_VALID), 32'(e_valid));
        check_eq("slip_ack",  32'(SLIP_ACK),  32'(e_ack));
        check_eq("slip_busy", 32'(SLIP_BUSY), 32'(e_busy));
        check_eq("slip_pos",  32'(SLIP_POS),  32'(e_pos));
        check_eq("slip_wrap", 32'(SLIP_WRAP), 32'(e_wrap));
    endtask

    // driver: one clock with the given inputs, model advanced, outputs checked
    task automatic tick(input logic req, input logic vld, input logic [W-1:0] din, input logic rev);
        int d;
        bit pre_idle, post_idle;
        int lane, r, nout;
        SLIP_REQ = req; IN_VALID = vld; IN_DATA = din; REV_EN = rev;

        pre_idle = (acc_edge < 0) || (n_edge - acc_edge >= SETTLE + 3);
        if (pre_idle && req) acc_edge = n_edge;
        d = (acc_edge < 0) ? 1000 : n_edge - acc_edge;

        if (vld) begin
            nout = 0;
            for (int k = 0; k < LANES; k++) begin
                lane = (int'(din) >> (k * RATIO)) & MASK;
                r = m_rev ? rev_f(lane) : lane;
                nout |= slip_f(r, m_prev[k], e_pos) << (k * RATIO);
                m_prev[k] = r;
            end
            e_out = nout;
        end
        m_rev = rev;

        post_idle = (d >= SETTLE + 2);
        if (d == 1) begin
            m_wrap_flag = (e_pos == RATIO - 1);
            e_pos = (e_pos + 1) % RATIO;
        end
        e_busy  = !post_idle;
        e_ack   = (d == SETTLE + 1);
        e_wrap  = e_ack && m_wrap_flag;
        e_valid = vld && post_idle;

        @(posedge SCLK);
        #1;
        n_edge++;
        if (SLIP_ACK) dut_acks++;
        if (SLIP_WRAP) dut_wraps++;
        check_all();
    endtask

    // asynchronous assert, release one step after an edge
    task automatic do_reset();
        RESETN = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge SCLK); #1;
        @(posedge SCLK); #1;
        RESETN = 1'b1;
    endtask

    initial begin
        logic [W-1:0] rd;
        logic r_req, r_vld, r_rev;
        n_edge = 0; dut_acks = 0; dut_wraps = 0;
        RESETN = 1'b0; IN_DATA = '0; IN_VALID = 1'b0; REV_EN = 1'b1; SLIP_REQ = 1'b0;
        model_reset();
        repeat (3) @(posedge SCLK);
        #1;
        check_all();
        RESETN = 1'b1;

        // reversal with default rev=1, then rev=0
        tick(0, 1, 8'b0001_0011, 1);
        check_eq("rev_on", 32'(OUT_DATA), 32'h8C);
        check_eq("rev_on_valid", 32'(OUT_VALID), 32'd1);
        tick(0, 0, 8'h00, 0);
        tick(0, 1, 8'b0001_0011, 0);
        check_eq("rev_off", 32'(OUT_DATA), 32'h13);

        // handshake timing for one step
        tick(1, 1, 8'h5A, 0);
        check_eq("hs_busy_c1", 32'(SLIP_BUSY), 32'd1);
        check_eq("hs_valid_c1", 32'(OUT_VALID), 32'd0);
        tick(0, 1, 8'h0A, 0);
        check_eq("hs_pos_c2", 32'(SLIP_POS), 32'd1);
        tick(0, 1, 8'h0A, 0);
        tick(0, 1, 8'h0A, 0);
        check_eq("hs_ack_c4", 32'(SLIP_ACK), 32'd1);
        check_eq("hs_valid_c4", 32'(OUT_VALID), 32'd0);
        tick(0, 1, 8'h0A, 0);
        check_eq("hs_busy_c5", 32'(SLIP_BUSY), 32'd0);

        // slip window at position 1, lane0 1010 then 0110
        tick(0, 1, 8'h0A, 0);
        tick(0, 1, 8'h06, 0);
        check_eq("slip_lane0", 32'(OUT_DATA[3:0]), 32'hD);

        // wrap: four steps from position 0, extra requests during settle ignored
        do_reset();
        dut_acks = 0; dut_wraps = 0;
        for (int s = 0; s < 4; s++) begin
            tick(1, 1, 8'(s), 1);
            tick(0, 1, 8'h33, 1);
            check_eq("wrap_pos", 32'(SLIP_POS), 32'((s + 1) % RATIO));
            tick(1, 0, 8'h00, 1);
            tick(0, 1, 8'hC5, 1);
            tick(0, 1, 8'h71, 1);
        end
        check_eq("wrap_ack_count", 32'(dut_acks), 32'd4);
        check_eq("wrap_pulse_count", 32'(dut_wraps), 32'd1);

        // reset while settling aborts the step
        tick(1, 1, 8'h11, 1);
        tick(0, 1, 8'h22, 1);
        do_reset();
        dut_acks = 0;
        repeat (5) tick(0, 1, 8'h44, 1);
        check_eq("abort_no_ack", 32'(dut_acks), 32'd0);
        tick(1, 1, 8'h55, 1);
        repeat (4) tick(0, 1, 8'h66, 1);
        check_eq("abort_retry_pos", 32'(SLIP_POS), 32'd1);
        check_eq("abort_retry_ack", 32'(dut_acks), 32'd1);

        // held request gives back-to-back steps
        repeat (12) tick(1, 1, 8'(n_edge), 1);

        // random traffic with occasional reset
        r_rev = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            r_req = ($urandom_range(0, 3) == 0);
            r_vld = ($urandom_range(0, 3) != 0);
            rd    = W'($urandom);
            if ($urandom_range(0, 9) == 0) r_rev = ~r_rev;
            tick(r_req, r_vld, rd, r_rev);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
